// File: rtl/plot_arbiter.sv
// Shares the VGA pixel-write port between background, sprite and overlay producers.
// Bursts are granted round-robin, and a built-in engine sweeps the whole screen with CLEAR_COLOR.
module plot_arbiter #(
  parameter int          SCREEN_W    = 320,
  parameter int          SCREEN_H    = 240,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  last,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  x2,
  input  logic [7:0]  y0,
  input  logic [7:0]  y1,
  input  logic [7:0]  y2,
  input  logic [11:0] c0,
  input  logic [11:0] c1,
  input  logic [11:0] c2,
  output logic [2:0]  ack,
  output logic [2:0]  grant,
  input  logic        clear,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [11:0] vga_c,
  output logic        vga_plot,
  output logic [16:0] bback_addr
);

  localparam logic [8:0]  X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0]  Y_LAST = 8'(SCREEN_H - 1);
  localparam logic [16:0] ROW_W  = 17'(SCREEN_W);

  typedef enum logic [1:0] {IDLE, ARB, BURST, CLEAR} state_t;

  state_t      state, state_nxt;
  logic [2:0]  grant_nxt;
  logic [2:0]  pick;
  logic [1:0]  last_srv;
  logic        clear_pend;
  logic        burst_end;
  logic [8:0]  cx;
  logic [7:0]  cy;
  logic        vld_p0;
  logic [8:0]  x_p0;
  logic [7:0]  y_p0;
  logic [11:0] c_p0;
  logic [16:0] addr_p0;

  // Search starts one past the last served requester and wraps.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ls);
    logic [2:0] p;
    p = 3'b000;
    case (ls)
      2'd0:    p = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
      2'd1:    p = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
      default: p = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    endcase
    return p;
  endfunction

  assign pick = rr_pick(req, last_srv);

  // Stage p0: pick the pixel that will be presented to the VGA adapter.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ack       = 3'b000;
    burst_end = 1'b0;
    vld_p0    = 1'b0;
    x_p0      = cx;
    y_p0      = cy;
    c_p0      = CLEAR_COLOR;
    case (state)
      IDLE: begin
        if (clear_pend)  state_nxt = CLEAR;
        else if (|req)   state_nxt = ARB;
      end
      ARB: begin
        grant_nxt = pick;
        state_nxt = (|pick) ? BURST : IDLE;
      end
      BURST: begin
        ack = grant & req;
        if (|ack) begin
          vld_p0 = 1'b1;
          if (grant[2]) begin
            x_p0 = x2; y_p0 = y2; c_p0 = c2;
          end else if (grant[1]) begin
            x_p0 = x1; y_p0 = y1; c_p0 = c1;
          end else begin
            x_p0 = x0; y_p0 = y0; c_p0 = c0;
          end
          if (|(ack & last)) begin
            burst_end = 1'b1;
            grant_nxt = 3'b000;
            state_nxt = IDLE;
          end
        end
      end
      CLEAR: begin
        vld_p0 = 1'b1;
        if (cx == X_LAST && cy == Y_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    addr_p0 = {9'd0, y_p0} * ROW_W + {8'd0, x_p0};
  end

  // Stage p1: registered pixel stream and control state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 3'b000;
      last_srv   <= 2'd2;
      clear_pend <= 1'b0;
      cx         <= 9'd0;
      cy         <= 8'd0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= 9'd0;
      vga_y      <= 8'd0;
      vga_c      <= 12'h000;
      bback_addr <= 17'd0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      vga_plot <= vld_p0;
      if (burst_end) last_srv <= {grant[2], grant[1]};
      if (state == IDLE && clear_pend)   clear_pend <= 1'b0;
      else if (clear && state != CLEAR)  clear_pend <= 1'b1;
      if (state == CLEAR) begin
        if (cx == X_LAST) begin
          cx <= 9'd0;
          cy <= (cy == Y_LAST) ? 8'd0 : cy + 8'd1;
        end else begin
          cx <= cx + 9'd1;
        end
      end else begin
        cx <= 9'd0;
        cy <= 8'd0;
      end
      // busy tracks the registered clear pixels; done fires once busy falls.
      clear_busy <= (state == CLEAR);
      clear_done <= clear_busy && (state != CLEAR);
      if (vld_p0) begin
        vga_x      <= x_p0;
        vga_y      <= y_p0;
        vga_c      <= c_p0;
        bback_addr <= addr_p0;
      end
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: vector table, randomized bursts against a round-robin stream model,
// and hand sequences for the clear sweep and asynchronous reset.
module tb_plot_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  last = 3'b000;
  logic [8:0]  xs[3];
  logic [7:0]  ys[3];
  logic [11:0] cs[3];
  logic        clear = 1'b0;
  logic [2:0]  ack, grant;
  logic        clear_busy, clear_done, vga_plot;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [11:0] vga_c;
  logic [16:0] bback_addr;

  int total = 0;
  int bad = 0;

  plot_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .last(last),
    .x0(xs[0]), .x1(xs[1]), .x2(xs[2]),
    .y0(ys[0]), .y1(ys[1]), .y2(ys[2]),
    .c0(cs[0]), .c1(cs[1]), .c2(cs[2]),
    .ack(ack), .grant(grant), .clear(clear),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_c(vga_c),
    .vga_plot(vga_plot), .bback_addr(bback_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_all(input logic [2:0] r, input logic [2:0] l, input logic [8:0] x,
                           input logic [7:0] y, input logic [11:0] c);
    req = r;
    last = l;
    for (int i = 0; i < 3; i++) begin
      xs[i] = x; ys[i] = y; cs[i] = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear = 1'b0;
    drive_all(3'b000, 3'b000, 9'd0, 8'd0, 12'h000);
    #1;
    resetn = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},   32'(ack), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_x"},     32'(vga_x), 0);
    chk({tag, "_y"},     32'(vga_y), 0);
    chk({tag, "_c"},     32'(vga_c), 0);
    chk({tag, "_plot"},  32'(vga_plot), 0);
    chk({tag, "_addr"},  32'(bback_addr), 0);
    chk({tag, "_busy"},  32'(clear_busy), 0);
    chk({tag, "_done"},  32'(clear_done), 0);
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req, last;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    logic [2:0]  e_ack, e_grant;
    logic        e_plot;
    logic [8:0]  e_x;
    logic [16:0] e_addr;
    logic [11:0] e_c;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [2:0] r, input logic [2:0] l, input int x,
                     input int y, input logic [11:0] c, input logic [2:0] ea, input logic [2:0] eg,
                     input logic ep, input int ex, input int eaddr, input logic [11:0] ec);
    vec_t v;
    v.rst = rst; v.req = r; v.last = l; v.x = 9'(x); v.y = 8'(y); v.c = c;
    v.e_ack = ea; v.e_grant = eg; v.e_plot = ep; v.e_x = 9'(ex); v.e_addr = 17'(eaddr); v.e_c = ec;
    vecs.push_back(v);
  endtask

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    logic        l;
  } pix_t;

  task automatic run_random(input int round);
    pix_t px[3][32];
    int   np[3], nb[3], ptr[3], pos[3], rem[3];
    pix_t expq[$];
    pix_t e;
    int   ls, last_end, owner;
    bit   prev_ack, new_burst, first, finished;
    for (int i = 0; i < 3; i++) begin
      np[i] = 0;
      nb[i] = $urandom_range(5, 2);
      for (int b = 0; b < nb[i]; b++) begin
        int len;
        len = $urandom_range(4, 1);
        for (int p = 0; p < len; p++) begin
          px[i][np[i]].x = 9'($urandom);
          px[i][np[i]].y = 8'($urandom);
          px[i][np[i]].c = 12'($urandom);
          px[i][np[i]].l = (p == len - 1);
          np[i]++;
        end
      end
      ptr[i] = 0; pos[i] = 0; rem[i] = nb[i];
    end
    // Expected stream: whole bursts, next owner = first pending after the last served.
    ls = 2;
    while (rem[0] + rem[1] + rem[2] > 0) begin
      int j;
      j = -1;
      for (int k = 1; k <= 3; k++)
        if (j < 0 && rem[(ls + k) % 3] > 0) j = (ls + k) % 3;
      do begin
        expq.push_back(px[j][pos[j]]);
        pos[j]++;
      end while (!px[j][pos[j] - 1].l);
      rem[j]--;
      ls = j;
    end
    do_reset();
    prev_ack = 0; new_burst = 1; first = 1; last_end = 0; finished = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      chk($sformatf("rnd%0d_plot_latency", round), 32'(vga_plot), 32'(prev_ack));
      if (vga_plot) begin
        if (expq.size() == 0) begin
          chk($sformatf("rnd%0d_extra_pixel", round), 1, 0);
        end else begin
          e = expq.pop_front();
          chk($sformatf("rnd%0d_x", round), 32'(vga_x), 32'(e.x));
          chk($sformatf("rnd%0d_y", round), 32'(vga_y), 32'(e.y));
          chk($sformatf("rnd%0d_c", round), 32'(vga_c), 32'(e.c));
          chk($sformatf("rnd%0d_addr", round), 32'(bback_addr),
              32'((int'(e.y) * 320 + int'(e.x)) % 131072));
        end
      end
      if (ptr[0] == np[0] && ptr[1] == np[1] && ptr[2] == np[2]) begin
        finished = 1;
        break;
      end
      for (int i = 0; i < 3; i++) begin
        if (ptr[i] < np[i]) begin
          req[i]  = !(grant[i] && !new_burst && $urandom_range(3) == 0);
          last[i] = px[i][ptr[i]].l;
          xs[i] = px[i][ptr[i]].x; ys[i] = px[i][ptr[i]].y; cs[i] = px[i][ptr[i]].c;
        end else begin
          req[i] = 1'b0;
          last[i] = 1'($urandom);
          xs[i] = 9'($urandom); ys[i] = 8'($urandom); cs[i] = 12'($urandom);
        end
      end
      #1;
      chk($sformatf("rnd%0d_ack_legal", round),
          32'(((ack & ~req) == 3'b000) && $onehot0(ack)), 1);
      prev_ack = |ack;
      if (|ack) begin
        owner = ack[2] ? 2 : ack[1] ? 1 : 0;
        if (new_burst) begin
          chk($sformatf("rnd%0d_gap", round), 32'(first ? cyc : cyc - last_end), first ? 2 : 3);
          first = 0;
          new_burst = 0;
        end
        if (owner < 3 && ptr[owner] < np[owner]) begin
          if (px[owner][ptr[owner]].l) begin
            new_burst = 1;
            last_end = cyc;
          end
          ptr[owner]++;
        end
      end
    end
    chk($sformatf("rnd%0d_finished", round), 32'(finished), 1);
    chk($sformatf("rnd%0d_drained", round), 32'(expq.size()), 0);
    drive_all(3'b000, 3'b000, 9'd0, 8'd0, 12'h000);
  endtask

  initial begin
    int a1, w, sweep_err, ex, ey;
    bit pulsed, busy_early, second;
    drive_all(3'b000, 3'b000, 9'd0, 8'd0, 12'h000);
    repeat (2) @(negedge clk);
    check_zero("reset");

    // Single sprite burst from reset.
    add(1, 3'b010, 3'b000, 10, 20, 12'hF00, 3'b000, 3'b000, 0, 0, 0, 12'h000);
    add(0, 3'b010, 3'b000, 10, 20, 12'hF00, 3'b000, 3'b000, 0, 0, 0, 12'h000);
    add(0, 3'b010, 3'b000, 10, 20, 12'hF00, 3'b010, 3'b010, 0, 0, 0, 12'h000);
    add(0, 3'b010, 3'b000, 11, 20, 12'hF00, 3'b010, 3'b010, 1, 10, 6410, 12'hF00);
    add(0, 3'b010, 3'b000, 12, 20, 12'hF00, 3'b010, 3'b010, 1, 11, 6411, 12'hF00);
    add(0, 3'b010, 3'b010, 13, 20, 12'hF00, 3'b010, 3'b010, 1, 12, 6412, 12'hF00);
    add(0, 3'b000, 3'b000, 13, 20, 12'hF00, 3'b000, 3'b000, 1, 13, 6413, 12'hF00);
    add(0, 3'b000, 3'b000, 13, 20, 12'hF00, 3'b000, 3'b000, 0, 0, 0, 12'h000);
    // Round-robin with one-pixel bursts: owners 0,1,2,0,1,2 every third cycle.
    for (int k = 0; k <= 18; k++) begin
      logic [2:0] ea;
      ea = (k >= 2 && k <= 17 && (k - 2) % 3 == 0) ? 3'(1 << (((k - 2) / 3) % 3)) : 3'b000;
      add(k == 0, (k < 18) ? 3'b111 : 3'b000, 3'b111, 30 + k, 5, 12'h0F0, ea, ea,
          (k >= 3 && (k - 3) % 3 == 0), 30 + k - 1, 1600 + 30 + k - 1, 12'h0F0);
    end
    // Overlay burst stalls for 5 cycles while background keeps requesting.
    add(1, 3'b010, 3'b111, 100, 1, 12'h00F, 3'b000, 3'b000, 0, 0, 0, 12'h000);
    add(0, 3'b010, 3'b111, 101, 1, 12'h00F, 3'b000, 3'b000, 0, 0, 0, 12'h000);
    add(0, 3'b010, 3'b111, 102, 1, 12'h00F, 3'b010, 3'b010, 0, 0, 0, 12'h000);
    add(0, 3'b101, 3'b000, 103, 1, 12'h00F, 3'b000, 3'b000, 1, 102, 422, 12'h00F);
    add(0, 3'b101, 3'b000, 104, 1, 12'h00F, 3'b000, 3'b000, 0, 0, 0, 12'h000);
    add(0, 3'b101, 3'b000, 105, 1, 12'h00F, 3'b100, 3'b100, 0, 0, 0, 12'h000);
    add(0, 3'b001, 3'b000, 106, 1, 12'h00F, 3'b000, 3'b100, 1, 105, 425, 12'h00F);
    for (int k = 7; k <= 10; k++)
      add(0, 3'b001, 3'b000, 100 + k, 1, 12'h00F, 3'b000, 3'b100, 0, 0, 0, 12'h000);
    add(0, 3'b101, 3'b100, 111, 1, 12'h00F, 3'b100, 3'b100, 0, 0, 0, 12'h000);
    add(0, 3'b000, 3'b000, 112, 1, 12'h00F, 3'b000, 3'b000, 1, 111, 431, 12'h00F);
    add(0, 3'b000, 3'b000, 113, 1, 12'h00F, 3'b000, 3'b000, 0, 0, 0, 12'h000);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rst) begin
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
      end
      clear = 1'b0;
      drive_all(vecs[i].req, vecs[i].last, vecs[i].x, vecs[i].y, vecs[i].c);
      #1;
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("vec%0d_plot", i), 32'(vga_plot), 32'(vecs[i].e_plot));
      if (vecs[i].e_plot) begin
        chk($sformatf("vec%0d_x", i), 32'(vga_x), 32'(vecs[i].e_x));
        chk($sformatf("vec%0d_addr", i), 32'(bback_addr), 32'(vecs[i].e_addr));
        chk($sformatf("vec%0d_c", i), 32'(vga_c), 32'(vecs[i].e_c));
      end
    end

    run_random(0);
    run_random(1);

    // Clear requested during a sprite burst, with all requesters active throughout.
    do_reset();
    a1 = 0; pulsed = 0; busy_early = 0;
    for (int k = 0; k < 40 && a1 < 3; k++) begin
      @(negedge clk);
      if (a1 >= 1 && !pulsed) begin
        clear = 1'b1;
        pulsed = 1;
      end else begin
        clear = 1'b0;
      end
      req = 3'b111;
      last = {1'b1, (a1 == 2), 1'b1};
      xs[0] = 9'd1;   ys[0] = 8'd2; cs[0] = 12'h111;
      xs[1] = 9'(200 + a1); ys[1] = 8'd7; cs[1] = 12'hABC;
      xs[2] = 9'd3;   ys[2] = 8'd4; cs[2] = 12'h222;
      if (clear_busy) busy_early = 1;
      #1;
      if (ack[1]) a1++;
    end
    clear = 1'b0;
    chk("clr_burst_acks", 32'(a1), 3);
    chk("clr_not_preempted", 32'(busy_early), 0);
    @(negedge clk);
    chk("clr_burst_last_plot", 32'(vga_plot), 1);
    chk("clr_burst_last_x", 32'(vga_x), 202);
    chk("clr_burst_last_addr", 32'(bback_addr), 2442);
    chk("clr_burst_last_busy", 32'(clear_busy), 0);
    w = 0;
    while (w < 10 && !clear_busy) begin
      @(negedge clk);
      w++;
    end
    chk("clr_start_delay", 32'(w), 2);
    chk("clr_first_x", 32'(vga_x), 0);
    chk("clr_first_y", 32'(vga_y), 0);
    chk("clr_first_addr", 32'(bback_addr), 0);
    sweep_err = 0;
    for (int n = 0; n < 76800; n++) begin
      if (n > 0) @(negedge clk);
      clear = (n == 1000);
      ex = n % 320;
      ey = n / 320;
      if (vga_x != 9'(ex) || vga_y != 8'(ey) || vga_c != 12'h000 || bback_addr != 17'(n) ||
          !vga_plot || !clear_busy || ack != 3'b000 || clear_done) begin
        if (sweep_err == 0)
          $display("FAIL clr_sweep pixel %0d: got x=%0d y=%0d c=%0h addr=%0d plot=%0b busy=%0b ack=%0b done=%0b, want x=%0d y=%0d c=0 addr=%0d plot=1 busy=1 ack=0 done=0",
                   n, vga_x, vga_y, vga_c, bback_addr, vga_plot, clear_busy, ack, clear_done,
                   ex, ey, n);
        sweep_err++;
      end
      if (n == 76799) begin
        chk("clr_last_x", 32'(vga_x), 319);
        chk("clr_last_y", 32'(vga_y), 239);
        chk("clr_last_addr", 32'(bback_addr), 76799);
      end
    end
    clear = 1'b0;
    total++;
    if (sweep_err != 0) bad++;
    @(negedge clk);
    chk("clr_busy_fall", 32'(clear_busy), 0);
    chk("clr_done_pulse", 32'(clear_done), 1);
    chk("clr_after_plot", 32'(vga_plot), 0);
    @(negedge clk);
    chk("clr_done_single", 32'(clear_done), 0);
    second = 0;
    w = 0;
    while (w < 10 && grant == 3'b000) begin
      if (clear_busy) second = 1;
      @(negedge clk);
      w++;
    end
    chk("clr_resume_grant", 32'(grant), 32'(3'b100));
    chk("clr_single_sweep", 32'(second | clear_busy), 0);

    // Asynchronous reset part-way through a clear sweep.
    do_reset();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    w = 0;
    while (w < 10 && !clear_busy) begin
      @(negedge clk);
      w++;
    end
    chk("rstclr_started", 32'(clear_busy), 1);
    for (int n = 0; n < 500; n++) @(negedge clk);
    chk("rstclr_px500_x", 32'(vga_x), 180);
    chk("rstclr_px500_y", 32'(vga_y), 1);
    resetn = 1'b0;
    #1;
    check_zero("rstclr");
    resetn = 1'b1;
    drive_all(3'b111, 3'b111, 9'd5, 8'd6, 12'h123);
    @(negedge clk);
    chk("rstclr_k1_grant", 32'(grant), 0);
    chk("rstclr_k1_busy", 32'(clear_busy), 0);
    @(negedge clk);
    chk("rstclr_k2_grant", 32'(grant), 32'(3'b001));
    chk("rstclr_k2_ack", 32'(ack), 32'(3'b001));
    chk("rstclr_k2_busy", 32'(clear_busy), 0);
    drive_all(3'b000, 3'b000, 9'd0, 8'd0, 12'h000);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
